stream_mux_arb: RTL and testbench
=================================

Name: stream_mux_arb

Overview:
Parametrised N-channel, W-bit stream multiplexer with a valid/ready handshake on every input and on the output, and a single registered output stage. It generalises the index-based 4:1 mux to any channel count and width. It adds three runtime-independent selection modes: external select, fixed priority and round-robin. It sits between several producer streams and one shared consumer. The output channel index travels with each data beat.

Parameters:
N_CH, 4, number of input channels; legal range N_CH >= 2.
W, 4, data width per channel; legal range W >= 1.
MODE, 2, selection mode from the package enum: 0 = SEL (external index), 1 = PRIO (lowest index wins), 2 = RR (round-robin).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous and active-high.
sel  input  CH_W  channel index, used only when MODE=SEL. CH_W = $clog2(N_CH).
in_valid  input  N_CH  bit i = channel i has a beat.
in_data  input  [W] x N_CH unpacked array [0:N_CH-1]  per-channel data.
in_ready  output  N_CH  bit i = channel i beat accepted this cycle when in_valid[i].
out_valid  output  1  registered beat present.
out_data  output  W  registered data.
out_ch  output  CH_W  index of the channel that supplied out_data.
out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset values, on any clk edge with rst=1: out_valid=0, out_data=0, out_ch=0, RR pointer last=N_CH-1. Channel 0 therefore wins first. rst overrides every other event, including a transfer in the same cycle; a held beat is discarded.
- Slot free condition: can_load = ~out_valid | out_ready. This is combinational, so out_ready feeds in_ready. No other combinational input-to-output path is allowed.
- Grant is a one-hot vector gnt[N_CH-1:0] computed each cycle from in_valid:
  - SEL: gnt[sel] = in_valid[sel]. If sel >= N_CH, gnt = 0.
  - PRIO: gnt is the lowest set bit of in_valid.
  - RR: gnt is the first set bit of in_valid searching last+1, last+2, ... with wrap modulo N_CH.
- in_ready = gnt & {N_CH{can_load}}. At most one bit is high. in_ready is 0 for every channel while rst=1.
- Transfer in: any(gnt) & can_load. On the next edge: out_valid=1, out_data=in_data[idx], out_ch=idx, and in RR mode last=idx.
- Drain with no new beat (out_valid & out_ready & ~any(gnt)): next edge out_valid=0. out_data and out_ch hold their last values.
- Stall (out_valid & ~out_ready): out_valid, out_data and out_ch are stable. in_ready=0. last is unchanged.
- Throughput and latency:
  - Full throughput: simultaneous drain and load in the same cycle gives one beat per cycle.
  - Input-to-output latency is 1 cycle.
- The RR pointer advances only on a transfer in. Idle cycles and stalls never move it.
- Fairness: under continuous requests from k channels, each is served once per k transfers.
- sel changes during a stall do not affect the held beat. They take effect on the next load.

Decomposition:
- Package stream_mux_pkg holds:
  - typedef enum mux_mode_e {SEL, PRIO, RR}
  - function ch_w(n) returning max(1, $clog2(n))
- One sub-module, rr_arbiter: purely combinational. Parameter N_CH; inputs req and last; output one-hot gnt. Implemented with the double-width rotate-and-mask trick. PRIO uses the same block with last tied to N_CH-1.
- The top level holds the output register, the pointer register and the mode select (generate on MODE).

Test Plan:
- Reset: in_valid=1111, rst=1 for 2 cycles -> in_ready=0000, out_valid=0, out_data=0, out_ch=0. First cycle after reset (RR) -> in_ready=0001, then out_ch=0.
- RR fairness: MODE=RR, in_valid=1111, in_data[i]=i+1, out_ready=1 -> out_ch sequence 0,1,2,3,0 and out_data sequence 1,2,3,4,1, one beat per cycle with no bubbles.
- Backpressure: beat out_ch=1/out_data=2 held, out_ready=0 for 3 cycles -> outputs stable, in_ready=0000. Release -> out_ch=2 on the next edge. No beat is lost or duplicated.
- Mode contrast: in_valid=1010 continuous. PRIO -> out_ch always 1. RR -> 1,3,1,3.
- SEL: MODE=SEL, sel=2, in_valid=1111 -> in_ready=0100 and out_ch=2. sel changed to 3 during a stall -> held beat unchanged, next beat out_ch=3.
- Sparse and mid-op reset:
  - Single ch3 beat -> out_valid high for one cycle, then 0. Then in_valid=1111 -> ch0 granted (pointer wrapped from 3).
  - rst asserted while out_valid=1 -> out_valid=0 next edge, beat dropped.

Source files
------------

// File: rtl/stream_mux_arb_pkg.sv
// rtl/stream_mux_arb_pkg.sv - shared types and helpers for stream_mux_arb
package stream_mux_pkg;

    typedef enum int {
        SEL  = 0,
        PRIO = 1,
        RR   = 2
    } mux_mode_e;

    // Channel index width; never narrower than one bit
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// rtl/stream_mux_arb_rr_arbiter.sv - combinational rotating first-set-bit arbiter
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last,
    output logic [N_CH-1:0] gnt
);

    logic [N_CH-1:0] rot;
    logic [N_CH-1:0] first;
    int              shamt;

    // Rotate so bit 0 is the channel after last, isolate lowest request, rotate back
    always_comb begin
        shamt = int'(last) + 1;
        rot   = N_CH'({req, req} >> shamt);
        first = rot & (-rot);
        gnt   = N_CH'(({first, first} << shamt) >> N_CH);
    end

endmodule

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-channel stream mux with selectable arbitration and one output register
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 4,
    parameter int MODE = 2,
    parameter int CH_W = ch_w(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH_W-1:0] sel,
    input  logic [N_CH-1:0] in_valid,
    input  logic [W-1:0]    in_data [0:N_CH-1],
    output logic [N_CH-1:0] in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [CH_W-1:0] out_ch,
    input  logic            out_ready
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;
    logic [CH_W-1:0] last_q, last_d;

    logic [N_CH-1:0] gnt;
    logic [CH_W-1:0] idx;
    logic            can_load;
    logic            load;
    logic            unused_sel;

    if (MODE == int'(SEL)) begin : g_sel
        assign unused_sel = 1'b0;
        // External index picks the channel; out-of-range index grants nothing
        always_comb begin
            gnt = '0;
            if (int'(sel) < N_CH) begin
                gnt[sel] = in_valid[sel];
            end
        end
    end else if (MODE == int'(PRIO)) begin : g_prio
        assign unused_sel = ^sel;
        rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
            .req  (in_valid),
            .last (CH_W'(N_CH - 1)),
            .gnt  (gnt)
        );
    end else begin : g_rr
        assign unused_sel = ^sel;
        rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
            .req  (in_valid),
            .last (last_q),
            .gnt  (gnt)
        );
    end

    // Encode the one-hot grant into a channel index
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                idx = CH_W'(i);
            end
        end
    end

    assign can_load = ~out_valid_q | out_ready;
    assign load     = (|gnt) & can_load;
    assign in_ready = rst ? '0 : (gnt & {N_CH{can_load}});

    // Load a granted beat, otherwise drain when the consumer takes the held one
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[idx];
            out_ch_d    = idx;
            if (MODE == int'(RR)) begin
                last_d = idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage and round-robin pointer; pointer resets so channel 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= CH_W'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - scoreboard bench for stream_mux_arb in RR, PRIO and SEL modes
module tb_stream_mux_arb;

    logic       clk;
    logic       rst;
    logic [1:0] sel;
    logic [3:0] din [0:3];

    logic [3:0] rr_v, pr_v, se_v;
    logic       rr_rdy, pr_rdy, se_rdy;
    logic [3:0] rr_ir, pr_ir, se_ir;
    logic       rr_ov, pr_ov, se_ov;
    logic [3:0] rr_od, pr_od, se_od;
    logic [1:0] rr_oc, pr_oc, se_oc;

    logic [5:0] q_rr [$];
    logic [5:0] q_pr [$];
    logic [5:0] q_se [$];

    int errors = 0;
    int checks = 0;

    stream_mux_arb #(.N_CH(4), .W(4), .MODE(2)) dut_rr (
        .clk(clk), .rst(rst), .sel(sel), .in_valid(rr_v), .in_data(din),
        .in_ready(rr_ir), .out_valid(rr_ov), .out_data(rr_od), .out_ch(rr_oc),
        .out_ready(rr_rdy)
    );

    stream_mux_arb #(.N_CH(4), .W(4), .MODE(1)) dut_pr (
        .clk(clk), .rst(rst), .sel(sel), .in_valid(pr_v), .in_data(din),
        .in_ready(pr_ir), .out_valid(pr_ov), .out_data(pr_od), .out_ch(pr_oc),
        .out_ready(pr_rdy)
    );

    stream_mux_arb #(.N_CH(4), .W(4), .MODE(0)) dut_se (
        .clk(clk), .rst(rst), .sel(sel), .in_valid(se_v), .in_data(din),
        .in_ready(se_ir), .out_valid(se_ov), .out_data(se_od), .out_ch(se_oc),
        .out_ready(se_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] beat(input int ch, input int data);
        return {2'(ch), 4'(data)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Consumer-side monitors: every accepted output beat must match the next expected one
    always @(negedge clk) begin
        if (rr_ov === 1'b1 && rr_rdy === 1'b1) begin
            if (q_rr.size() == 0) chk("rr_extra_beat", {rr_oc, rr_od}, 32'hFFFF);
            else chk("rr_beat", {rr_oc, rr_od}, q_rr.pop_front());
        end
    end

    always @(negedge clk) begin
        if (pr_ov === 1'b1 && pr_rdy === 1'b1) begin
            if (q_pr.size() == 0) chk("prio_extra_beat", {pr_oc, pr_od}, 32'hFFFF);
            else chk("prio_beat", {pr_oc, pr_od}, q_pr.pop_front());
        end
    end

    always @(negedge clk) begin
        if (se_ov === 1'b1 && se_rdy === 1'b1) begin
            if (q_se.size() == 0) chk("sel_extra_beat", {se_oc, se_od}, 32'hFFFF);
            else chk("sel_beat", {se_oc, se_od}, q_se.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) din[i] = 4'(i + 1);
        sel = 2'd0;
        rr_v = 4'b1111; pr_v = 4'b1111; se_v = 4'b1111;
        rr_rdy = 1'b1; pr_rdy = 1'b1; se_rdy = 1'b1;

        // Reset with all channels requesting
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", rr_ir, 4'b0000);
        chk("rst_prio_in_ready", pr_ir, 4'b0000);
        chk("rst_out_valid", rr_ov, 1'b0);
        chk("rst_out_data", rr_od, 4'h0);
        chk("rst_out_ch", rr_oc, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; pr_v = 4'b0000; se_v = 4'b0000;

        // RR fairness: 0,1,2,3,0 back to back
        for (int i = 0; i < 5; i++) q_rr.push_back(beat(i % 4, (i % 4) + 1));
        @(negedge clk);
        chk("first_rr_in_ready", rr_ir, 4'b0001);
        repeat (5) @(posedge clk);
        #1 rr_v = 4'b0000;
        @(negedge clk);
        chk("rr_no_bubble_valid", rr_ov, 1'b1);
        step();
        @(negedge clk);
        chk("rr_drained", rr_ov, 1'b0);
        chk("rr_queue_empty", q_rr.size(), 0);

        // Backpressure: ch1 held for 3 stalled cycles, then ch2 follows
        step();
        rr_v = 4'b1111; rr_rdy = 1'b0;
        q_rr.push_back(beat(1, 2));
        q_rr.push_back(beat(2, 3));
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", rr_ov, 1'b1);
            chk("stall_ch", rr_oc, 2'd1);
            chk("stall_data", rr_od, 4'd2);
            chk("stall_in_ready", rr_ir, 4'b0000);
            step();
        end
        rr_rdy = 1'b1;
        step();
        rr_v = 4'b0000;
        chk("release_ch", rr_oc, 2'd2);
        step();
        step();
        chk("bp_drained", rr_ov, 1'b0);
        chk("bp_queue_empty", q_rr.size(), 0);

        // Mode contrast from a fresh pointer: in_valid=1010
        do_reset();
        rr_v = 4'b1010; pr_v = 4'b1010; rr_rdy = 1'b1; pr_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q_rr.push_back((i % 2 == 0) ? beat(1, 2) : beat(3, 4));
            q_pr.push_back(beat(1, 2));
        end
        repeat (4) @(posedge clk);
        #1;
        rr_v = 4'b0000; pr_v = 4'b0000;
        step();
        step();
        chk("mode_rr_queue_empty", q_rr.size(), 0);
        chk("mode_prio_queue_empty", q_pr.size(), 0);

        // SEL: sel=2 granted, sel change during stall does not disturb held beat
        se_v = 4'b1111; sel = 2'd2; se_rdy = 1'b0;
        q_se.push_back(beat(2, 3));
        @(negedge clk);
        chk("sel_in_ready", se_ir, 4'b0100);
        step();
        sel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("sel_stall_ch", se_oc, 2'd2);
            chk("sel_stall_data", se_od, 4'd3);
            chk("sel_stall_in_ready", se_ir, 4'b0000);
            step();
        end
        q_se.push_back(beat(3, 4));
        se_rdy = 1'b1;
        step();
        se_v = 4'b0000;
        chk("sel_next_ch", se_oc, 2'd3);
        step();
        step();
        chk("sel_queue_empty", q_se.size(), 0);

        // Sparse: lone ch3 beat, then all request and pointer wraps to ch0
        rr_v = 4'b1000; rr_rdy = 1'b1;
        q_rr.push_back(beat(3, 4));
        step();
        rr_v = 4'b0000;
        @(negedge clk);
        chk("sparse_valid_hi", rr_ov, 1'b1);
        step();
        chk("sparse_valid_lo", rr_ov, 1'b0);
        rr_v = 4'b1111;
        q_rr.push_back(beat(0, 1));
        @(negedge clk);
        chk("wrap_in_ready", rr_ir, 4'b0001);
        step();
        rr_v = 4'b0000;
        step();
        chk("sparse_queue_empty", q_rr.size(), 0);

        // Mid-operation reset drops a held beat
        rr_v = 4'b1111; rr_rdy = 1'b0;
        step();
        rr_v = 4'b0000;
        @(negedge clk);
        chk("pre_rst_valid", rr_ov, 1'b1);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_valid", rr_ov, 1'b0);
        chk("midrst_ch", rr_oc, 2'd0);
        chk("midrst_data", rr_od, 4'd0);
        rst = 1'b0;
        rr_rdy = 1'b1;
        step();
        step();
        chk("final_rr_queue_empty", q_rr.size(), 0);
        chk("final_prio_queue_empty", q_pr.size(), 0);
        chk("final_sel_queue_empty", q_se.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
